// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - Wishbone B4 pipelined responder backed by a word-addressed RAM
// Fixed-latency acks from an in-order queue; stall when the queue is full or forced.
module wb_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic        force_stall_i
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int GW = $clog2(LATENCY + 1);

  logic [31:0]   mem    [DEPTH_WORDS];
  logic [31:0]   q_data [QUEUE_DEPTH];
  logic [GW-1:0] q_age  [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] idx;
  logic          accept;
  logic          head_due;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign idx        = wb_adr_i[AW+1:2];
  assign wb_stall_o = force_stall_i | (count == CW'(QUEUE_DEPTH));
  assign accept     = !rst_i & wb_cyc_i & wb_stb_i & !wb_stall_o;

  // Ages advance in lockstep, so only the head can ever reach LATENCY.
  assign head_due = (count != '0) && (q_age[rd_ptr] == GW'(LATENCY));
  assign wb_ack_o = !rst_i & wb_cyc_i & head_due;
  assign wb_dat_o = wb_ack_o ? q_data[rd_ptr] : 32'h0;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (wb_we_i) begin
        for (int n = 0; n < 4; n++) begin
          if (wb_sel_i[n]) mem[idx][8*n +: 8] <= wb_dat_i[8*n +: 8];
        end
        q_data[wr_ptr] <= 32'h0;
      end else begin
        q_data[wr_ptr] <= mem[idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !wb_cyc_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_age[i] != GW'(LATENCY)) q_age[i] <= q_age[i] + GW'(1);
      end
      if (accept) begin
        q_age[wr_ptr] <= GW'(1);
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (wb_ack_o) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(accept) - CW'(wb_ack_o);
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// tb/tb_wb_mem_responder.sv - self-checking bench for wb_mem_responder
// Reference model schedules each accepted request for cycle accept+LAT and tracks RAM words.
module tb_wb_mem_responder;
  localparam int LAT = 2;
  localparam int QD  = 2;
  localparam int DW  = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic        wb_stall_o;
  logic        force_stall_i = 1'b0;

  always #5 clk_i = ~clk_i;

  wb_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT), .QUEUE_DEPTH(QD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
    .force_stall_i(force_stall_i)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] ref_mem [DW];
  int          cyc_no   = 0;
  int          checks   = 0;
  int          failures = 0;
  logic        obs_ack, obs_stall, obs_acc;
  logic [31:0] obs_dat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_no, got, exp);
    end
  endtask

  // One bus cycle: drive, compare outputs against the model, advance the model at the edge.
  task automatic step(input logic c, input logic s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] sl, input logic f, input logic r);
    logic        exp_stall, exp_ack, acc;
    logic [31:0] exp_dat;
    int          ix;
    pend_t       e;
    wb_cyc_i = c; wb_stb_i = s; wb_we_i = w; wb_adr_i = a;
    wb_dat_i = d; wb_sel_i = sl; force_stall_i = f; rst_i = r;
    #1;
    exp_stall = f || (pend.size() == QD);
    exp_ack   = !r && c && (pend.size() > 0) && (pend[0].due == cyc_no);
    exp_dat   = exp_ack ? pend[0].data : 32'h0;
    obs_ack = wb_ack_o; obs_stall = wb_stall_o; obs_dat = wb_dat_o;
    chk("stall", {31'b0, wb_stall_o}, {31'b0, exp_stall});
    chk("ack", {31'b0, wb_ack_o}, {31'b0, exp_ack});
    chk("dat", wb_dat_o, exp_dat);
    acc     = !r && c && s && !exp_stall;
    obs_acc = acc;
    ix      = int'(a[11:2]);
    if (r || !c) begin
      pend.delete();
    end else begin
      if (exp_ack) void'(pend.pop_front());
      if (acc) begin
        e.due = cyc_no + LAT;
        if (w) begin
          for (int n = 0; n < 4; n++) if (sl[n]) ref_mem[ix][8*n +: 8] = d[8*n +: 8];
          e.data = 32'h0;
        end else begin
          e.data = ref_mem[ix];
        end
        pend.push_back(e);
      end
    end
    @(negedge clk_i);
    cyc_no++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    step(1'b1, 1'b1, 1'b1, a, d, sl, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b1, 1'b0, a, 32'h0, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    repeat (2) @(negedge clk_i);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    chk("reset_stall", {31'b0, obs_stall}, 32'd0);
    chk("reset_dat", obs_dat, 32'd0);

    // Prefill words 0..15 so every later read has a known value.
    for (int i = 0; i < 16; i++) begin
      obs_acc = 1'b0;
      for (int t = 0; t < 8 && !obs_acc; t++) wr(32'(i * 4), $urandom, 4'hF);
      chk("prefill_accept", {31'b0, obs_acc}, 32'd1);
    end
    repeat (4) idle();

    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10);
    idle();
    chk("rw_wr_ack", {31'b0, obs_ack}, 32'd1);
    chk("rw_wr_dat", obs_dat, 32'h0);
    idle();
    chk("rw_rd_ack", {31'b0, obs_ack}, 32'd1);
    chk("rw_rd_dat", obs_dat, 32'hDEADBEEF);

    wr(32'h10, 32'h000000AA, 4'b0001);
    rd(32'h10);
    idle();
    idle();
    chk("lane_dat", obs_dat, 32'hDEADBEAA);

    rd(32'h10);
    rd(32'h10);
    rd(32'h10);
    chk("full_stall", {31'b0, obs_stall}, 32'd1);
    chk("full_ack0", {31'b0, obs_ack}, 32'd1);
    rd(32'h10);
    chk("full_free", {31'b0, obs_stall}, 32'd0);
    chk("full_ack1", {31'b0, obs_ack}, 32'd1);
    idle();
    chk("full_gap", {31'b0, obs_ack}, 32'd0);
    idle();
    chk("full_ack2", {31'b0, obs_ack}, 32'd1);
    chk("full_dat2", obs_dat, 32'hDEADBEAA);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0);
      chk("force_stall", {31'b0, obs_stall}, 32'd1);
      chk("force_noack", {31'b0, obs_ack}, 32'd0);
    end
    rd(32'h10);
    chk("force_accept", {31'b0, obs_acc}, 32'd1);
    idle();
    idle();
    chk("force_ack", {31'b0, obs_ack}, 32'd1);

    wr(32'h20, 32'h12345678, 4'hF);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("abort_noack", {31'b0, obs_ack}, 32'd0);
    end
    rd(32'h20);
    idle();
    idle();
    chk("abort_commit", obs_dat, 32'h12345678);

    wr(32'h1000, 32'hCAFEF00D, 4'hF);
    rd(32'h0);
    idle();
    idle();
    chk("wrap_dat", obs_dat, 32'hCAFEF00D);

    rd(32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rst_noack", {31'b0, obs_ack}, 32'd0);
      chk("rst_stall", {31'b0, obs_stall}, 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      ra[11:6] = '0;
      step(logic'($urandom_range(0, 19) != 0), logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)), ra, $urandom, 4'($urandom),
           logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 96) == 0));
    end
    repeat (4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
